cordic_nco_mc: RTL and testbench
================================

# cordic_nco_mc

Multi-channel, time-multiplexed CORDIC numerically controlled oscillator. It keeps NUM_CH independent phase accumulators, each with its own programmable frequency and phase offset, and services them round-robin through one shared pipelined CORDIC rotator. It emits sin/cos samples tagged with their channel index. It sits in the signal-generation path between the register/config interface and the downstream mixers and DACs.

## Interface
- NUM_CH, 4: number of channels; must be a power of two, 1 to 16.
- PHASE_W, 32: accumulator, tuning-word and offset width. Unsigned, in turns: 2^PHASE_W = 2π.
- OUT_W, 16: signed sin/cos output width.
- STAGES, 16: CORDIC iterations, 8 to 24.
- AMPL, 16'h4DBA: initial x vector, gain-compensated (0.60725·(2^(OUT_W-1)-1)).
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  sample enable; each ce cycle services one channel
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = frequency tuning word, 1 = phase offset
- cfg_ch  in  log2(NUM_CH) (min 1)  channel addressed by the write
- cfg_data  in  PHASE_W  value written
- sync_in  in  1  zero all accumulators and restart the channel sequence
- sin_out  out  OUT_W  signed sine sample
- cos_out  out  OUT_W  signed cosine sample
- ch_out  out  log2(NUM_CH)  channel index of the current sample
- valid_out  out  1  sample valid

## Operation
- Channel counter `sel` runs 0 → NUM_CH-1 → 0 and advances only on ce cycles.
- On a ce cycle serving channel c:
  - issue angle = acc[c] + off[c] (mod 2^PHASE_W), truncated to its top ANGLE_W = OUT_W+2 bits;
  - update acc[c] <= acc[c] + fcw[c] (mod 2^PHASE_W).
- Phase wrap is natural modulo 2^PHASE_W. There is no compare and no snap to zero.
- Quadrant fold:
  - Treat the angle as signed turns in [-½, ½).
  - If its top two bits are 01 or 10, invert the MSB (subtract ½ turn) and set a `neg` flag that travels with the sample.
  - At the output, negate x and y when `neg` is set.
- CORDIC rotation mode:
  - x0 = AMPL, y0 = 0; internal x/y width is OUT_W+2.
  - Stage i: d = sign(z); x -= d·(y>>>i); y += d·(x>>>i); z -= d·atan_i.
  - atan_i = atan(2^-i)/(2π)·2^ANGLE_W, taken from a fixed 24-entry constant table.
- Output stage: apply `neg`, saturate to ±(2^(OUT_W-1)-1) so angle 0 gives +32767, never a wrapped value.
- Config writes land in fcw[] or off[] on the write clock edge.
  - If a write targets the channel being serviced in that same cycle, that cycle uses the old value.
- sync_in:
  - clears every acc[] and sets sel to 0;
  - has priority over the ce update in the same cycle;
  - samples already in the pipeline still emerge;
  - fcw[] and off[] are kept.
- rst:
  - clears acc[], fcw[], off[], sel, and every pipeline valid bit;
  - sets sin_out, cos_out, ch_out to 0 and valid_out to 0.

## Timing
- The pipeline advances every clock, independent of ce. ce only sets the stage-0 valid bit.
- Latency L = STAGES+2 clocks, from the ce cycle to valid_out with the matching ch_out (18 at defaults).
- valid_out is ce delayed by L. Throughput is one sample per ce.
- When valid_out is low, sin_out/cos_out/ch_out hold their last values.
- rst mid-operation: valid_out is 0 from the cycle after rst is sampled. No stale in-flight sample is ever flagged valid.
- Config writes take effect for the next service of the addressed channel, i.e. up to NUM_CH ce cycles later.

## Test plan
- **Reset / DC:** rst, then ce=1 with all registers zero.
  - valid_out rises 18 cycles after the first ce.
  - ch_out runs 0,1,2,3,0,…
  - cos_out = 32767 (saturated) and sin_out within ±8 LSB of 0 on all channels.
- **Phase offsets:** off[1]=0x4000_0000, off[2]=0x8000_0000, off[3]=0xC000_0000.
  - ch1 gives sin ≈ +32767, cos ≈ 0.
  - ch2 gives cos ≈ −32767, sin ≈ 0.
  - ch3 gives sin ≈ −32767, cos ≈ 0.
  - Tolerance ±8 LSB.
- **Frequency and wrap:** fcw[0]=0x0400_0000.
  - ch0 sample k matches round(32767·sin(2πk/64)) within ±8.
  - Period is exactly 64 ch0 samples.
  - The accumulator step 0xFC00_0000 → 0x0000_0000 produces no discontinuity.
- **ce gating:** ce pattern 1,0,0,1,1,0,1.
  - valid_out reproduces the pattern 18 cycles later.
  - ch_out continues 0,1,2,3 across the gaps.
  - acc[] advances only on ce cycles.
- **sync and same-cycle write:**
  - Pulse sync_in mid-run: the next issued sample is ch0 with phase = off[0].
  - Write fcw[c] on the cycle channel c is serviced: that service uses the old fcw, the next service uses the new one.
- **Reset mid-stream:** assert rst with the pipeline full.
  - valid_out = 0 and outputs = 0 the next cycle.
  - No valid sample appears until 18 cycles after ce resumes.

Source files
------------

// File: rtl/cordic_nco_mc.sv
// Multi-channel time-multiplexed CORDIC NCO.
// NUM_CH phase accumulators share one pipelined CORDIC rotator, serviced
// round-robin on ce cycles. Output samples carry their channel index.
module cordic_nco_mc #(
   parameter int NUM_CH  = 4,
   parameter int PHASE_W = 32,
   parameter int OUT_W   = 16,
   parameter int STAGES  = 16,
   parameter logic signed [OUT_W-1:0] AMPL = 16'sh4DBA
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic                     cfg_we,
   input  logic                     cfg_sel,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic [PHASE_W-1:0]       cfg_data,
   input  logic                     sync_in,
   output logic signed [OUT_W-1:0]  sin_out,
   output logic signed [OUT_W-1:0]  cos_out,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_out,
   output logic                     valid_out
);

   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int ANGLE_W = OUT_W + 2;
   localparam int XY_W    = OUT_W + 2;
   localparam logic signed [XY_W-1:0] POS_LIM = XY_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [XY_W-1:0] NEG_LIM = -POS_LIM;

   // atan(2^-i)/(2*pi) in units of 2^-18 turn, rescaled to the angle width
   function automatic logic signed [ANGLE_W-1:0] atan_tab(input int i);
      longint t;
      case (i)
         0:  t = 32768;
         1:  t = 19344;
         2:  t = 10221;
         3:  t = 5188;
         4:  t = 2604;
         5:  t = 1303;
         6:  t = 652;
         7:  t = 326;
         8:  t = 163;
         9:  t = 81;
         10: t = 41;
         11: t = 20;
         12: t = 10;
         13: t = 5;
         14: t = 3;
         15: t = 1;
         16: t = 1;
         default: t = 0;
      endcase
      return ANGLE_W'((t << ANGLE_W) >> 18);
   endfunction

   // Undo the half-turn fold: rotating by pi negates the vector
   function automatic logic signed [XY_W-1:0] apply_neg(input logic n,
                                                       input logic signed [XY_W-1:0] v);
      return n ? -v : v;
   endfunction

   // Clamp symmetrically so full scale never wraps to the opposite sign
   function automatic logic signed [OUT_W-1:0] sat(input logic signed [XY_W-1:0] v);
      if (v > POS_LIM)      return POS_LIM[OUT_W-1:0];
      else if (v < NEG_LIM) return NEG_LIM[OUT_W-1:0];
      else                  return v[OUT_W-1:0];
   endfunction

   logic [PHASE_W-1:0] r_acc [NUM_CH];
   logic [PHASE_W-1:0] r_fcw [NUM_CH];
   logic [PHASE_W-1:0] r_off [NUM_CH];
   logic [CH_W-1:0]    r_sel;

   logic signed [XY_W-1:0]    r_x_p   [0:STAGES];
   logic signed [XY_W-1:0]    r_y_p   [0:STAGES];
   logic signed [ANGLE_W-1:0] r_z_p   [0:STAGES];
   logic                      r_neg_p [0:STAGES];
   logic [CH_W-1:0]           r_ch_p  [0:STAGES];
   logic                      r_vld_p [0:STAGES];

   logic signed [OUT_W-1:0] r_sin;
   logic signed [OUT_W-1:0] r_cos;
   logic [CH_W-1:0]         r_ch;
   logic                    r_valid;

   logic [PHASE_W-1:0]        w_phase;
   logic [ANGLE_W-1:0]        w_ang;
   logic                      w_neg;
   logic signed [ANGLE_W-1:0] w_z0;
   logic                      w_unused_lsb;

   assign w_phase = r_acc[r_sel] + r_off[r_sel];
   assign w_ang   = w_phase[PHASE_W-1 -: ANGLE_W];
   // phase bits below the angle resolution are simply dropped
   assign w_unused_lsb = ^w_phase[PHASE_W-ANGLE_W-1:0];
   // angles in the outer half-plane (top bits 01/10) are moved by half a turn
   assign w_neg = w_ang[ANGLE_W-1] ^ w_ang[ANGLE_W-2];
   assign w_z0  = w_neg ? $signed({~w_ang[ANGLE_W-1], w_ang[ANGLE_W-2:0]})
                        : $signed(w_ang);

   // Config registers: a same-cycle service still reads the old value
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_fcw[k] <= '0;
            r_off[k] <= '0;
         end
      end else if (cfg_we) begin
         if (cfg_sel) r_off[cfg_ch] <= cfg_data;
         else         r_fcw[cfg_ch] <= cfg_data;
      end
   end

   // Channel sequencer, accumulators and the sample-valid chain
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) r_acc[k] <= '0;
         r_sel <= '0;
         for (int i = 0; i <= STAGES; i++) r_vld_p[i] <= 1'b0;
      end else begin
         r_vld_p[0] <= ce & ~sync_in;
         for (int i = 0; i < STAGES; i++) r_vld_p[i+1] <= r_vld_p[i];
         if (sync_in) begin
            for (int k = 0; k < NUM_CH; k++) r_acc[k] <= '0;
            r_sel <= '0;
         end else if (ce) begin
            r_acc[r_sel] <= r_acc[r_sel] + r_fcw[r_sel];
            r_sel <= (r_sel == CH_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
         end
      end
   end

   // Data pipeline: p0 = folded angle, p1..pSTAGES = CORDIC micro-rotations
   always_ff @(posedge clk) begin
      r_x_p[0]   <= XY_W'(AMPL);
      r_y_p[0]   <= '0;
      r_z_p[0]   <= w_z0;
      r_neg_p[0] <= w_neg;
      r_ch_p[0]  <= r_sel;
      for (int i = 0; i < STAGES; i++) begin
         if (!r_z_p[i][ANGLE_W-1]) begin
            r_x_p[i+1] <= r_x_p[i] - (r_y_p[i] >>> i);
            r_y_p[i+1] <= r_y_p[i] + (r_x_p[i] >>> i);
            r_z_p[i+1] <= r_z_p[i] - atan_tab(i);
         end else begin
            r_x_p[i+1] <= r_x_p[i] + (r_y_p[i] >>> i);
            r_y_p[i+1] <= r_y_p[i] - (r_x_p[i] >>> i);
            r_z_p[i+1] <= r_z_p[i] + atan_tab(i);
         end
         r_neg_p[i+1] <= r_neg_p[i];
         r_ch_p[i+1]  <= r_ch_p[i];
      end
   end

   // Output stage: unfold, saturate, hold last sample while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sin   <= '0;
         r_cos   <= '0;
         r_ch    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_vld_p[STAGES];
         if (r_vld_p[STAGES]) begin
            r_sin <= sat(apply_neg(r_neg_p[STAGES], r_y_p[STAGES]));
            r_cos <= sat(apply_neg(r_neg_p[STAGES], r_x_p[STAGES]));
            r_ch  <= r_ch_p[STAGES];
         end
      end
   end

   assign sin_out   = r_sin;
   assign cos_out   = r_cos;
   assign ch_out    = r_ch;
   assign valid_out = r_valid;

endmodule

// File: tb/tb_cordic_nco_mc.sv
// Scoreboard bench for cordic_nco_mc: stimulus pushes expected samples,
// a negedge monitor pops and compares whenever valid_out is seen.
module tb_cordic_nco_mc;

   localparam int LAT = 18;
   localparam int TOL = 8;

   logic clk = 1'b0;
   logic rst, ce, cfg_we, cfg_sel, sync_in;
   logic [1:0]  cfg_ch;
   logic [31:0] cfg_data;
   logic signed [15:0] sin_out, cos_out;
   logic [1:0]  ch_out;
   logic        valid_out;

   cordic_nco_mc #(.NUM_CH(4), .PHASE_W(32), .OUT_W(16), .STAGES(16)) dut (
      .clk(clk), .rst(rst), .ce(ce), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_ch(cfg_ch), .cfg_data(cfg_data), .sync_in(sync_in),
      .sin_out(sin_out), .cos_out(cos_out), .ch_out(ch_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct { int cyc; int ch; int s; int c; } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   logic [31:0] m_acc [4];
   logic [31:0] m_fcw [4];
   logic [31:0] m_off [4];
   int          m_sel = 0;

   bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
   bit wr_done;

   // Ideal 32767-scaled sine/cosine of a phase in turns
   function automatic int ideal(input logic [31:0] ph, input bit want_sin);
      real a, v;
      int  r;
      a = 6.283185307179586 * real'(ph) / 4294967296.0;
      v = 32767.0 * (want_sin ? $sin(a) : $cos(a));
      r = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
      if (r > 32767)  r = 32767;
      if (r < -32767) r = -32767;
      return r;
   endfunction

   task automatic check_eq(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_tol(input string name, input int act, input int req);
      total++;
      if (act > req + TOL || act < req - TOL) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d +/-%0d (cycle %0d)", name, act, req, TOL, cyc);
      end
   endtask

   // Drive one clock of inputs and advance the reference model as the DUT will
   task automatic tick(input bit c, input bit sy, input bit we, input bit ws,
                       input int wch, input logic [31:0] wd, input bit r);
      logic [31:0] ph;
      exp_t e;
      ce = c; sync_in = sy; cfg_we = we; cfg_sel = ws; cfg_ch = 2'(wch);
      cfg_data = wd; rst = r;
      if (r) begin
         for (int k = 0; k < 4; k++) begin
            m_acc[k] = '0; m_fcw[k] = '0; m_off[k] = '0;
         end
         m_sel = 0;
         while (sb_q.size() > 0 && sb_q[$].cyc > cyc) void'(sb_q.pop_back());
      end else begin
         if (sy) begin
            for (int k = 0; k < 4; k++) m_acc[k] = '0;
            m_sel = 0;
         end else if (c) begin
            ph    = m_acc[m_sel] + m_off[m_sel];
            e.cyc = cyc + LAT;
            e.ch  = m_sel;
            e.s   = ideal(ph, 1'b1);
            e.c   = ideal(ph, 1'b0);
            sb_q.push_back(e);
            m_acc[m_sel] = m_acc[m_sel] + m_fcw[m_sel];
            m_sel = (m_sel + 1) % 4;
         end
         if (we) begin
            if (ws) m_off[wch] = wd;
            else    m_fcw[wch] = wd;
         end
      end
      @(posedge clk);
      #1;
      ce = 1'b0; sync_in = 1'b0; cfg_we = 1'b0; rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
   endtask

   task automatic run(input int n);
      repeat (n) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
   endtask

   task automatic cfg(input bit ws, input int ch, input logic [31:0] d);
      tick(1'b0, 1'b0, 1'b1, ws, ch, d, 1'b0);
   endtask

   // Monitor: flag missing or unexpected samples, compare each valid one
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
         total++;
         bad++;
         $display("FAIL missing_sample: ch %0d due cycle %0d, valid_out low, required high",
                  sb_q[0].ch, sb_q[0].cyc);
         void'(sb_q.pop_front());
      end
      if (valid_out !== 1'b0) begin
         if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: valid_out=%b ch_out=%0d at cycle %0d, required 0",
                     valid_out, ch_out, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("ch_out", int'(ch_out), mon_e.ch);
            check_tol("sin_out", int'(sin_out), mon_e.s);
            check_tol("cos_out", int'(cos_out), mon_e.c);
         end
      end
   end

   initial begin
      rst = 1'b1; ce = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; sync_in = 1'b0;
      cfg_ch = '0; cfg_data = '0;
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
      check_eq("reset_valid", int'(valid_out), 0);
      check_eq("reset_sin", int'(sin_out), 0);
      check_eq("reset_cos", int'(cos_out), 0);
      check_eq("reset_ch", int'(ch_out), 0);

      // DC: all registers zero
      run(12);
      idle(LAT + 2);

      // Quarter-turn phase offsets
      cfg(1'b1, 1, 32'h4000_0000);
      cfg(1'b1, 2, 32'h8000_0000);
      cfg(1'b1, 3, 32'hC000_0000);
      run(8);
      idle(LAT + 2);

      // 1/64-turn step on ch0, more than a full period through the wrap
      cfg(1'b0, 0, 32'h0400_0000);
      run(260);
      idle(LAT + 2);

      // ce gating pattern
      for (int i = 0; i < 7; i++) tick(pat[i], 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      idle(LAT + 2);

      // sync_in mid-run, then restart from ch0 at off[0]
      cfg(1'b1, 0, 32'h2000_0000);
      cfg(1'b0, 2, 32'h0080_0000);
      run(6);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      run(4);

      // fcw write on the very cycle ch2 is serviced
      wr_done = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!wr_done && m_sel == 2 && i >= 4) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0, 2, 32'h0100_0000, 1'b0);
            wr_done = 1'b1;
         end else begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
         end
      end
      idle(LAT + 2);

      // Reset with the pipeline full
      run(LAT + 4);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
      check_eq("midrst_valid", int'(valid_out), 0);
      check_eq("midrst_sin", int'(sin_out), 0);
      check_eq("midrst_cos", int'(cos_out), 0);
      check_eq("midrst_ch", int'(ch_out), 0);
      idle(5);
      run(4);
      idle(LAT + 4);

      check_eq("scoreboard_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
